// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared types and constants for the 8-bit CPU control sequencer:
//          stage encoding, opcode field codes and the control strobe bundle
//          driven by cpu_ctrl_dec.
// Rev    : 1.0  initial release
// ============================================================================
package cpu_pkg;

  localparam int C_AW = 8;
  localparam int C_DW = 8;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_FETCHA = 3'd1,
    S_FETCHB = 3'd2,
    S_EXECA  = 3'd3,
    S_EXECB  = 3'd4
  } state_t;

  // Opcode group field op[7:5]
  localparam logic [2:0] C_GRP_MEM = 3'b000;
  localparam logic [2:0] C_GRP_JMP = 3'b001;
  localparam logic [2:0] C_GRP_ALU = 3'b100;

  // Sub field op[4:3] within the MEM group
  localparam logic [1:0] C_SUB_LD  = 2'b01;
  localparam logic [1:0] C_SUB_ST  = 2'b10;

  // Jump encodings: unconditional JMP is 001_11_111, conditionals use r
  localparam logic [1:0] C_SUB_JMP = 2'b11;
  localparam logic [2:0] C_J_JMP   = 3'b111;
  localparam logic [2:0] C_J_C     = 3'b000;
  localparam logic [2:0] C_J_NC    = 3'b001;
  localparam logic [2:0] C_J_Z     = 3'b010;
  localparam logic [2:0] C_J_NZ    = 3'b011;

  localparam logic [C_DW-1:0] C_HLT = 8'h00;

  typedef struct packed {
    logic [C_AW-1:0] addr;
    logic            rden;
    logic            wren;
    logic            pc_inc;
    logic            pc_load;
    logic [C_AW-1:0] pc_in;
    logic [2:0]      asel;
    logic [2:0]      bsel;
    logic [2:0]      csel;
    logic            cload;
    logic            cin_sel;
    logic            alu_ena;
    logic [1:0]      alu_ctrl;
  } ctrl_t;

  // Condition evaluation for the four conditional jumps; other codes never
  // take the branch.
  function automatic logic jump_taken(input logic [2:0] cond,
                                      input logic       cflag,
                                      input logic       zflag);
    logic taken;
    taken = 1'b0;
    case (cond)
      C_J_C:   taken = cflag;
      C_J_NC:  taken = ~cflag;
      C_J_Z:   taken = zflag;
      C_J_NZ:  taken = ~zflag;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cpu_ctrl_dec.sv
`default_nettype none
// ============================================================================
// Module : cpu_ctrl_dec
// Brief  : Purely combinational strobe decoder for the CPU sequencer.
// Ports  : state        - current stage
//          ira          - latched opcode
//          opnd         - operand (ram_q bypass in EXECA, irb otherwise)
//          pc_out       - current pc, used as fetch address
//          cflag/zflag  - alu flags for conditional jumps
//          ctrl         - control strobe bundle
// Rev    : 1.0  initial release
// ============================================================================
module cpu_ctrl_dec
  import cpu_pkg::*;
(
  input  state_t          state,
  input  logic [C_DW-1:0] ira,
  input  logic [C_DW-1:0] opnd,
  input  logic [C_AW-1:0] pc_out,
  input  logic            cflag,
  input  logic            zflag,
  output ctrl_t           ctrl
);

  logic [2:0] w_grp;
  logic [1:0] w_sub;
  logic [2:0] w_r;
  logic [2:0] w_ra;
  logic [2:0] w_rb;
  logic       w_unused;

  assign w_grp    = ira[7:5];
  assign w_sub    = ira[4:3];
  assign w_r      = ira[2:0];
  assign w_ra     = opnd[7:5];
  assign w_rb     = opnd[4:2];
  assign w_unused = &{1'b0, opnd[1:0]};

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCHA, S_FETCHB: begin
        ctrl.addr   = pc_out;
        ctrl.rden   = 1'b1;
        ctrl.pc_inc = 1'b1;
      end
      S_EXECA: begin
        case (w_grp)
          C_GRP_MEM: begin
            if (w_sub == C_SUB_LD) begin
              ctrl.addr = opnd;
              ctrl.rden = 1'b1;
            end else if (w_sub == C_SUB_ST) begin
              ctrl.addr = opnd;
              ctrl.asel = w_r;
              ctrl.wren = 1'b1;
            end
          end
          C_GRP_ALU: begin
            ctrl.asel     = w_ra;
            // INC/DEC are single-operand; keep bsel quiet for them
            ctrl.bsel     = w_sub[1] ? w_rb : 3'd0;
            ctrl.alu_ena  = 1'b1;
            ctrl.alu_ctrl = w_sub;
          end
          C_GRP_JMP: begin
            ctrl.pc_in = opnd;
            if (w_sub == C_SUB_JMP && w_r == C_J_JMP)
              ctrl.pc_load = 1'b1;
            else
              ctrl.pc_load = jump_taken(w_r, cflag, zflag);
          end
          default: ;
        endcase
      end
      S_EXECB: begin
        if (w_grp == C_GRP_MEM && w_sub == C_SUB_LD) begin
          ctrl.cload   = 1'b1;
          ctrl.csel    = w_r;
          ctrl.cin_sel = 1'b0;
        end else if (w_grp == C_GRP_ALU) begin
          ctrl.cload   = 1'b1;
          ctrl.csel    = w_ra;
          ctrl.cin_sel = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule : cpu_ctrl_dec
`default_nettype wire

// File: rtl/cpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module : cpu_ctrl
// Brief  : Stage sequencer for the 8-bit CPU. Owns the 5-state stage FSM,
//          the instruction registers ira/irb and the pending-halt flag, and
//          drives the pc, register file, alu and RAM strobes via
//          cpu_ctrl_dec.
// Ports  : clk, rst                 - clock, synchronous active-high reset
//          run, halt                - start / stop-at-boundary requests
//          ram_q, pc_out            - RAM read data, current pc
//          cflag, zflag             - alu flags
//          waits..execb             - one-hot stage indicators
//          addr, rden, wren         - RAM port controls
//          pc_inc, pc_load, pc_in   - pc controls
//          asel, bsel, csel, cload  - register file controls
//          cin_sel, alu_ena, alu_ctrl - datapath / alu controls
//          ira, irb                 - opcode / operand registers
// Rev    : 1.0  initial release
// ============================================================================
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int AW = C_AW,
  parameter int DW = C_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          halt,
  input  logic [DW-1:0] ram_q,
  input  logic [AW-1:0] pc_out,
  input  logic          cflag,
  input  logic          zflag,
  output logic          waits,
  output logic          fetcha,
  output logic          fetchb,
  output logic          execa,
  output logic          execb,
  output logic [AW-1:0] addr,
  output logic          rden,
  output logic          wren,
  output logic          pc_inc,
  output logic          pc_load,
  output logic [AW-1:0] pc_in,
  output logic [2:0]    asel,
  output logic [2:0]    bsel,
  output logic [2:0]    csel,
  output logic          cload,
  output logic          cin_sel,
  output logic          alu_ena,
  output logic [1:0]    alu_ctrl,
  output logic [DW-1:0] ira,
  output logic [DW-1:0] irb
);

  state_t        r_state;
  state_t        w_next;
  logic [DW-1:0] r_ira;
  logic [DW-1:0] r_irb;
  logic          r_halt_pend;
  logic [DW-1:0] w_opnd;
  ctrl_t         w_dec;
  ctrl_t         w_ctrl;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_WAIT;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT:   if (run) w_next = S_FETCHA;
      S_FETCHA: w_next = S_FETCHB;
      S_FETCHB: w_next = S_EXECA;
      S_EXECA:  w_next = S_EXECB;
      S_EXECB:  w_next = (r_ira == C_HLT || r_halt_pend) ? S_WAIT : S_FETCHA;
      default:  w_next = S_WAIT;
    endcase
  end

  // ------------------------------------------- instruction regs / halt
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ira       <= '0;
      r_irb       <= '0;
      r_halt_pend <= 1'b0;
    end else begin
      if (r_state == S_FETCHB) r_ira <= ram_q;
      if (r_state == S_EXECA)  r_irb <= ram_q;
      // Clearing on WAIT entry takes priority so a halt raised in the last
      // EXECB is not carried into the next run.
      if (w_next == S_WAIT)
        r_halt_pend <= 1'b0;
      else if (r_state != S_WAIT && halt)
        r_halt_pend <= 1'b1;
    end
  end

  // The operand byte is still on ram_q during EXECA; irb captures it on the
  // way out for use in EXECB.
  assign w_opnd = (r_state == S_EXECA) ? ram_q : r_irb;

  cpu_ctrl_dec u_dec (
    .state  (r_state),
    .ira    (r_ira),
    .opnd   (w_opnd),
    .pc_out (pc_out),
    .cflag  (cflag),
    .zflag  (zflag),
    .ctrl   (w_dec)
  );

  // Strobes are forced low while rst is high so an instruction aborted by
  // reset can neither write RAM nor load a register on the reset edge.
  assign w_ctrl = rst ? '0 : w_dec;

  // ---------------------------------------------------------- outputs
  assign waits    = (r_state == S_WAIT);
  assign fetcha   = (r_state == S_FETCHA);
  assign fetchb   = (r_state == S_FETCHB);
  assign execa    = (r_state == S_EXECA);
  assign execb    = (r_state == S_EXECB);

  assign addr     = w_ctrl.addr;
  assign rden     = w_ctrl.rden;
  assign wren     = w_ctrl.wren;
  assign pc_inc   = w_ctrl.pc_inc;
  assign pc_load  = w_ctrl.pc_load;
  assign pc_in    = w_ctrl.pc_in;
  assign asel     = w_ctrl.asel;
  assign bsel     = w_ctrl.bsel;
  assign csel     = w_ctrl.csel;
  assign cload    = w_ctrl.cload;
  assign cin_sel  = w_ctrl.cin_sel;
  assign alu_ena  = w_ctrl.alu_ena;
  assign alu_ctrl = w_ctrl.alu_ctrl;

  assign ira      = r_ira;
  assign irb      = r_irb;

endmodule : cpu_ctrl
`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu_ctrl
// Brief  : Directed self-checking bench for cpu_ctrl with a small RAM and pc
//          model standing in for the datapath.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cpu_ctrl;

  logic       clk = 1'b0;
  logic       rst, run, halt, cflag, zflag;
  logic [7:0] ram_q = 8'h00;
  logic [7:0] r_pc  = 8'h00;
  logic       waits, fetcha, fetchb, execa, execb;
  logic [7:0] addr, pc_in, ira, irb;
  logic       rden, wren, pc_inc, pc_load, cload, cin_sel, alu_ena;
  logic [2:0] asel, bsel, csel;
  logic [1:0] alu_ctrl;
  logic [7:0] mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_ctrl #(.AW(8), .DW(8)) dut (
    .clk(clk), .rst(rst), .run(run), .halt(halt), .ram_q(ram_q),
    .pc_out(r_pc), .cflag(cflag), .zflag(zflag),
    .waits(waits), .fetcha(fetcha), .fetchb(fetchb), .execa(execa),
    .execb(execb), .addr(addr), .rden(rden), .wren(wren),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_in(pc_in),
    .asel(asel), .bsel(bsel), .csel(csel), .cload(cload),
    .cin_sel(cin_sel), .alu_ena(alu_ena), .alu_ctrl(alu_ctrl),
    .ira(ira), .irb(irb)
  );

  // Datapath stand-ins: registered RAM read and pc counter
  always @(posedge clk) if (rden) ram_q <= mem[addr];
  always @(posedge clk) begin
    if (rst)          r_pc <= 8'h00;
    else if (pc_load) r_pc <= pc_in;
    else if (pc_inc)  r_pc <= r_pc + 8'h01;
  end

  logic [4:0] w_stage;
  logic [6:0] w_strb;
  assign w_stage = {waits, fetcha, fetchb, execa, execb};
  assign w_strb  = {rden, wren, pc_inc, pc_load, cload, alu_ena, cin_sel};

  localparam logic [4:0] C_WT = 5'b10000, C_FA = 5'b01000, C_FB = 5'b00100,
                         C_EA = 5'b00010, C_EB = 5'b00001;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reset, load the two instruction bytes at 0, pulse run; returns in FETCHA
  task automatic start(input logic [7:0] op, input logic [7:0] opnd);
    rst = 1'b1;
    step();
    rst    = 1'b0;
    mem[0] = op;
    mem[1] = opnd;
    run    = 1'b1;
    step();
    run = 1'b0;
    check("start_fetcha", w_stage, C_FA);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h5C;
    rst = 1'b1; run = 1'b0; halt = 1'b0; cflag = 1'b0; zflag = 1'b0;
    repeat (2) step();

    // Reset state
    check("rst_stage", w_stage, C_WT);
    check("rst_strb",  w_strb, 7'd0);
    check("rst_addr",  addr, 8'h00);
    check("rst_ira",   ira, 8'h00);
    check("rst_irb",   irb, 8'h00);
    rst = 1'b0;
    step();
    check("wait_hold", w_stage, C_WT);

    // HLT: full walk through the stages back to WAIT
    start(8'h00, 8'h00);
    check("hlt_fa_addr", addr, 8'h00);
    check("hlt_fa_strb", w_strb, 7'b1010000);
    step();
    check("hlt_fb_stage", w_stage, C_FB);
    check("hlt_fb_addr",  addr, 8'h01);
    check("hlt_fb_strb",  w_strb, 7'b1010000);
    step();
    check("hlt_ea_stage", w_stage, C_EA);
    check("hlt_ea_strb",  w_strb, 7'd0);
    step();
    check("hlt_eb_stage", w_stage, C_EB);
    check("hlt_eb_strb",  w_strb, 7'd0);
    step();
    check("hlt_wait", w_stage, C_WT);
    check("hlt_wait_strb", w_strb, 7'd0);

    // LD r2, [0x10]
    start(8'h0A, 8'h10);
    step(); step();
    check("ld_ea_addr", addr, 8'h10);
    check("ld_ea_strb", w_strb, 7'b1000000);
    check("ld_ira",     ira, 8'h0A);
    step();
    check("ld_eb_strb", w_strb, 7'b0000100);
    check("ld_eb_csel", csel, 3'd2);
    check("ld_irb",     irb, 8'h10);
    step();
    check("ld_next_fa", w_stage, C_FA);
    check("ld_next_addr", addr, 8'h02);

    // ST r3, [0x20]
    start(8'h13, 8'h20);
    step(); step();
    check("st_ea_addr", addr, 8'h20);
    check("st_ea_strb", w_strb, 7'b0100000);
    check("st_ea_asel", asel, 3'd3);
    step();
    check("st_eb_strb", w_strb, 7'd0);

    // ALU op 0x98 (ss=11), operand ra=1 rb=1
    start(8'h98, 8'h24);
    step(); step();
    check("alu_ea_strb", w_strb, 7'b0000010);
    check("alu_ea_ctrl", alu_ctrl, 2'd3);
    check("alu_ea_asel", asel, 3'd1);
    check("alu_ea_bsel", bsel, 3'd1);
    step();
    check("alu_eb_strb", w_strb, 7'b0000101);
    check("alu_eb_csel", csel, 3'd1);

    // JZ 0x40, not taken
    start(8'h3A, 8'h40);
    step(); step();
    check("jz0_pc_load", pc_load, 1'b0);
    step(); step();
    check("jz0_next_addr", addr, 8'h02);

    // JZ 0x40, taken
    zflag = 1'b1;
    start(8'h3A, 8'h40);
    step(); step();
    check("jz1_pc_load", pc_load, 1'b1);
    check("jz1_pc_in",   pc_in, 8'h40);
    step(); step();
    check("jz1_next_addr", addr, 8'h40);
    zflag = 1'b0;

    // JMP 0x00 with both flags clear
    start(8'h3F, 8'h00);
    step(); step();
    check("jmp_pc_load", pc_load, 1'b1);
    step(); step();
    check("jmp_next_addr", addr, 8'h00);

    // JNC taken / JC not taken with cflag=0
    start(8'h39, 8'h77);
    step(); step();
    check("jnc_pc_load", pc_load, 1'b1);
    check("jnc_pc_in",   pc_in, 8'h77);
    start(8'h38, 8'h77);
    step(); step();
    check("jc_pc_load", pc_load, 1'b0);

    // Undefined opcode behaves as a NOP and does not stop
    start(8'hE0, 8'h00);
    step(); step();
    check("nop_ea_strb", w_strb, 7'd0);
    step(); step();
    check("nop_continue", w_stage, C_FA);

    // halt raised in FETCHB: instruction completes, then WAIT
    start(8'h98, 8'h24);
    step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt_ea", w_stage, C_EA);
    step();
    check("halt_eb_cload", cload, 1'b1);
    step();
    check("halt_wait", w_stage, C_WT);

    // run and halt together in WAIT: run wins
    halt = 1'b1; run = 1'b1;
    step();
    halt = 1'b0; run = 1'b0;
    check("runhalt_fa", w_stage, C_FA);

    // Reset during EXECA of ST aborts the write
    start(8'h13, 8'h20);
    step(); step();
    check("strst_ea_wren", wren, 1'b1);
    rst = 1'b1;
    #1;
    check("strst_gated_wren", wren, 1'b0);
    step();
    check("strst_stage", w_stage, C_WT);
    check("strst_wren",  wren, 1'b0);
    check("strst_ira",   ira, 8'h00);
    check("strst_irb",   irb, 8'h00);
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_cpu_ctrl
`default_nettype wire
